// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed MUL/DIV engine that owns the HI/LO result
// registers. It processes one bit per clock on operand magnitudes and applies
// sign correction in a final cycle.
//
// Ports:
//   Clock      system clock, rising edge
//   Clear      synchronous active-high reset; aborts any operation in flight
//   Start      operation request, sampled only while idle
//   Control    opcode; only MUL_CODE and DIV_CODE are accepted
//   reg_A      multiplicand / dividend (signed)
//   reg_B      multiplier / divisor (signed)
//   Busy       high while an accepted operation is in flight
//   Done       one-cycle completion pulse; HI/LO are valid in the same cycle
//   DivByZero  sticky flag, set by a DIV with a zero divisor
//   HI, LO     MUL: product high/low words; DIV: remainder/quotient
//
// state | meaning
// IDLE  | waiting for an accepted Start
// CALC  | one shift/add or shift/subtract iteration per clock
// FIX   | sign correction, HI/LO write, Done pulse

module muldiv_sequencer #(
   parameter int         WIDTH    = 32,
   parameter logic [4:0] MUL_CODE = 5'b01111,
   parameter logic [4:0] DIV_CODE = 5'b10000
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Start,
   input  logic [4:0]       Control,
   input  logic [WIDTH-1:0] reg_A,
   input  logic [WIDTH-1:0] reg_B,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;       // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opb;       // MUL: multiplicand magnitude; DIV: divisor magnitude
   logic               op_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;

   logic               start_ok;
   logic               start_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign start_ok  = Start && ((Control == MUL_CODE) || (Control == DIV_CODE));
   assign start_div = (Control == DIV_CODE);
   assign sign_a    = reg_A[WIDTH-1];
   assign sign_b    = reg_B[WIDTH-1];
   assign a_mag     = sign_a ? -reg_A : reg_A;
   assign b_mag     = sign_b ? -reg_B : reg_B;

   // Shift-add: the carry out of the upper half re-enters as the new MSB.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring step: the remainder is always below the divisor, so the shifted
   // value fits in WIDTH+1 bits and bit WIDTH of the difference is the borrow.
   assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
   assign rem_diff  = rem_shift - {1'b0, opb};
   assign div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

   assign quo  = acc[WIDTH-1:0];
   assign rem  = acc[2*WIDTH-1:WIDTH];
   assign Busy = (state != IDLE);

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         opb       <= '0;
         op_div    <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         div_zero  <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  DivByZero <= 1'b0;
                  cnt       <= '0;
                  op_div    <= start_div;
                  neg_res   <= sign_a ^ sign_b;
                  if (start_div) begin
                     opb      <= b_mag;
                     acc      <= {{WIDTH{1'b0}}, a_mag};
                     neg_rem  <= sign_a;
                     div_zero <= (reg_B == '0);
                     state    <= (reg_B == '0) ? FIX : CALC;
                  end else begin
                     opb      <= a_mag;
                     acc      <= {{WIDTH{1'b0}}, b_mag};
                     neg_rem  <= 1'b0;
                     div_zero <= 1'b0;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= op_div ? div_next : mul_next;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) state <= FIX;
            end
            FIX: begin
               Done  <= 1'b1;
               state <= IDLE;
               if (op_div && div_zero) begin
                  // Dividend magnitude is still in the low half; restoring its
                  // sign returns the original reg_A.
                  HI        <= neg_rem ? -quo : quo;
                  LO        <= {WIDTH{1'b1}};
                  DivByZero <= 1'b1;
               end else if (op_div) begin
                  LO <= neg_res ? -quo : quo;
                  HI <= neg_rem ? -rem : rem;
               end else begin
                  {HI, LO} <= neg_res ? -acc : acc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
